hazard_control_unit: RTL and testbench
======================================

# hazard_control_unit

Pipeline hazard controller for the uDLX core. It sits beside the EX-stage forwarding mux and sequences the pipeline registers around it. It detects load-use hazards that forwarding cannot cover and flushes wrong-path instructions on taken branches. It freezes the whole pipeline while data memory is busy, and a watchdog traps memory waits that run too long.

## Interface
- `REG_ADDR_WIDTH`, 5: register address width.
- `TIMEOUT`, 256: maximum consecutive `mem_stall` cycles before fault; must be ≥2.
- `CNT_WIDTH`, 32: statistics counter width.

- `clk` in 1: core clock.
- `rst_n` in 1: reset. One clock; reset is synchronous and active-low.
- `id_rs_addr` in REG_ADDR_WIDTH: ID-stage source A register.
- `id_rt_addr` in REG_ADDR_WIDTH: ID-stage source B register.
- `id_rs_used` in 1: ID instruction reads rs.
- `id_rt_used` in 1: ID instruction reads rt.
- `ex_rd_addr` in REG_ADDR_WIDTH: EX-stage destination register.
- `ex_reg_wr_ena` in 1: EX instruction writes a register.
- `ex_mem_rd` in 1: EX instruction is a load.
- `ex_branch_taken` in 1: branch resolved taken in EX.
- `mem_stall` in 1: data memory not ready this cycle.
- `fault_clr` in 1: software/debug acknowledge of fault.
- `pc_wr_ena` out 1: PC update enable.
- `if_id_wr_ena` out 1: IF/ID register enable.
- `id_ex_wr_ena` out 1: ID/EX register enable.
- `ex_mem_wr_ena` out 1: EX/MEM and MEM/WB register enable.
- `if_id_flush` out 1: clear IF/ID to NOP.
- `id_ex_flush` out 1: load NOP into ID/EX (bubble).
- `fault` out 1: memory watchdog tripped (registered).
- `stall_cycles` out CNT_WIDTH: load-use stall cycles counted.
- `mem_wait_cycles` out CNT_WIDTH: memory freeze cycles counted.
- `flush_count` out CNT_WIDTH: taken-branch flushes counted.

## Operation
- FSM states: RUN, MEM_WAIT, FAULT. Registered state, Mealy control outputs.
- Reset: state RUN, `wait_cnt`=0, `fault`=0, all counters 0.
- Default outputs in RUN with idle inputs: all `*_wr_ena`=1, both flushes 0.
- Load-use hazard (`lu`) requires all of:
  - `ex_mem_rd & ex_reg_wr_ena`;
  - `ex_rd_addr != 0`;
  - `(id_rs_used & id_rs_addr==ex_rd_addr) | (id_rt_used & id_rt_addr==ex_rd_addr)`.
- RUN evaluates conditions in priority order:
  1. `mem_stall`: all four `*_wr_ena`=0, no flush. Next state MEM_WAIT, or FAULT when the watchdog trips.
  2. `ex_branch_taken`: `if_id_flush`=1, `id_ex_flush`=1, enables stay 1. Any `lu` in the same cycle is ignored because the ID instruction is wrong-path.
  3. `lu`: `pc_wr_ena`=0, `if_id_wr_ena`=0, `id_ex_flush`=1. Exactly one bubble is inserted; next cycle the load sits in MEM and forwarding covers it.
- MEM_WAIT: all enables 0, no flush. On `mem_stall`=0, return to RUN and apply the RUN rules in that same cycle. Branch and hazard conditions are held by the frozen stages and are not latched.
- Watchdog:
  - `wait_cnt` increments on every edge with `mem_stall`=1 (RUN or MEM_WAIT) and clears on `mem_stall`=0.
  - At an edge with `mem_stall`=1 and `wait_cnt`==TIMEOUT-1: state becomes FAULT, `fault` becomes 1, `wait_cnt` clears.
- FAULT: all enables 0, no flush, `mem_stall` ignored. `fault_clr`=1 moves to RUN and clears `fault` at the next edge.
- Counters saturate at all-ones; they never wrap.
  - `stall_cycles` increments on cycles where `lu` takes effect.
  - `mem_wait_cycles` increments on cycles with enables frozen by `mem_stall`.
  - `flush_count` increments on cycles where branch flush takes effect.
- A reset mid-stall or in FAULT returns to RUN with everything cleared. An asserted `mem_stall` then re-enters MEM_WAIT, counting from 0.

## Timing
- Control outputs are combinational from state plus inputs, so there is zero-cycle latency to pipeline enables.
- The input-to-output path must fit before the pipeline register setup.
- `fault` is registered. With `mem_stall` high for TIMEOUT consecutive cycles, `fault` rises at the end of cycle TIMEOUT.
- A load-use hazard costs exactly 1 cycle; a taken branch costs 2 squashed instructions and 0 stall cycles.
- Counters update at the edge ending the qualifying cycle.

## Configuration
- `HAZARD_STATS_EN` defined: the three counters are implemented as described.
- Not defined: counter ports are tied to 0 and no counter flops are built. Control behaviour is identical either way.

## Structure
- Shared package `udlx_pkg` holds the state encoding constants (RUN=2'd0, MEM_WAIT=2'd1, FAULT=2'd2) and the default TIMEOUT.
- One sub-module, `stall_watchdog`, holds `wait_cnt`, the compare and the trip pulse.
- FSM, hazard compare and counters stay in the top.

## Test plan
- Load `r5`, then an ID instruction with rs=`r5` used → one cycle with `pc_wr_ena`=0, `if_id_wr_ena`=0, `id_ex_flush`=1; `stall_cycles`=1.
- Load to `r0` with an ID instruction reading `r0` → no stall; all enables 1.
- `ex_branch_taken`=1 together with a load-use match on `r3` → both flushes 1, `pc_wr_ena`=1; `flush_count`=1, `stall_cycles`=0.
- `mem_stall` high 3 cycles during a load-use match → enables 0 for 3 cycles, then 1 stall cycle; `mem_wait_cycles`=3.
- TIMEOUT=4, `mem_stall` held high → `fault`=1 after 4th cycle. Dropping `mem_stall` keeps FAULT; `fault_clr` pulse returns to RUN with `fault`=0.
- `rst_n`=0 for one edge while in FAULT → RUN, `fault`=0, counters 0.

Source files
------------

// File: rtl/udlx_pkg.sv
// Shared uDLX definitions: hazard controller state encoding and default sizes.
// Imported by the hazard_control_unit slice (interface, watchdog, top).
package udlx_pkg;

  // Hazard controller FSM encoding.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } hcu_state_e;

  localparam int unsigned REG_ADDR_WIDTH_DEFAULT = 5;
  localparam int unsigned TIMEOUT_DEFAULT        = 256;
  localparam int unsigned CNT_WIDTH_DEFAULT      = 32;

endpackage : udlx_pkg

// File: rtl/hazard_control_unit_if.sv
// Pipeline <-> hazard controller bus.
//   master : pipeline side; drives ID/EX hazard info, mem_stall and fault_clr,
//            and receives stage enables, flushes, fault and statistics.
//   slave  : hazard_control_unit side (the reverse directions).
interface hazard_control_unit_if
  import udlx_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEFAULT,
  parameter int unsigned CNT_WIDTH      = CNT_WIDTH_DEFAULT
);

  logic [REG_ADDR_WIDTH-1:0] id_rs_addr;
  logic [REG_ADDR_WIDTH-1:0] id_rt_addr;
  logic                      id_rs_used;
  logic                      id_rt_used;
  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr;
  logic                      ex_reg_wr_ena;
  logic                      ex_mem_rd;
  logic                      ex_branch_taken;
  logic                      mem_stall;
  logic                      fault_clr;

  logic                      pc_wr_ena;
  logic                      if_id_wr_ena;
  logic                      id_ex_wr_ena;
  logic                      ex_mem_wr_ena;
  logic                      if_id_flush;
  logic                      id_ex_flush;
  logic                      fault;
  logic [CNT_WIDTH-1:0]      stall_cycles;
  logic [CNT_WIDTH-1:0]      mem_wait_cycles;
  logic [CNT_WIDTH-1:0]      flush_count;

  modport master (
    output id_rs_addr, id_rt_addr, id_rs_used, id_rt_used,
           ex_rd_addr, ex_reg_wr_ena, ex_mem_rd, ex_branch_taken,
           mem_stall, fault_clr,
    input  pc_wr_ena, if_id_wr_ena, id_ex_wr_ena, ex_mem_wr_ena,
           if_id_flush, id_ex_flush, fault,
           stall_cycles, mem_wait_cycles, flush_count
  );

  modport slave (
    input  id_rs_addr, id_rt_addr, id_rs_used, id_rt_used,
           ex_rd_addr, ex_reg_wr_ena, ex_mem_rd, ex_branch_taken,
           mem_stall, fault_clr,
    output pc_wr_ena, if_id_wr_ena, id_ex_wr_ena, ex_mem_wr_ena,
           if_id_flush, id_ex_flush, fault,
           stall_cycles, mem_wait_cycles, flush_count
  );

endinterface : hazard_control_unit_if

// File: rtl/hazard_control_unit_stall_watchdog.sv
// stall_watchdog: counts consecutive mem_stall cycles and pulses o_trip_c
// in the cycle whose closing edge would be the TIMEOUT-th stalled edge.
//   clk, rst_n   : clock, synchronous active-low reset
//   i_ena        : counting allowed (low while the controller sits in FAULT)
//   i_mem_stall  : data memory not ready this cycle
//   o_trip_c     : combinational trip pulse, consumed by the state register
module stall_watchdog
  import udlx_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_ena,
  input  logic i_mem_stall,
  output logic o_trip_c
);

  localparam int unsigned WCW = $clog2(TIMEOUT);

  logic [WCW-1:0] r_wait_cnt;

  assign o_trip_c = i_ena & i_mem_stall & (r_wait_cnt == WCW'(TIMEOUT - 1));

  // Count stalled edges; any non-stalled edge, FAULT or a trip restarts from 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (!i_ena || !i_mem_stall || o_trip_c) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= r_wait_cnt + WCW'(1);
    end
  end

endmodule : stall_watchdog

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: uDLX pipeline hazard controller.
// Detects unforwardable load-use hazards (one bubble), flushes IF/ID and
// ID/EX on taken branches, freezes every stage while data memory stalls and
// traps to FAULT when a memory wait reaches TIMEOUT cycles.
//   clk, rst_n : clock, synchronous active-low reset
//   hz (slave) : hazard inputs, stage enables/flushes (combinational, Mealy),
//                fault (registered), statistics counters
// Build option: define HAZARD_STATS_EN to implement the saturating counters;
// otherwise the counter outputs are tied to zero.
module hazard_control_unit
  import udlx_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEFAULT,
  parameter int unsigned TIMEOUT        = TIMEOUT_DEFAULT,
  parameter int unsigned CNT_WIDTH      = CNT_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hazard_control_unit_if.slave hz
);

  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG = '0;

  hcu_state_e r_state;
  hcu_state_e w_state_nxt;
  logic       r_fault;
  logic       w_trip;
  logic       w_lu;
  logic       w_lu_take;
  logic       w_br_take;
  logic       w_freeze;
  logic       w_pc_wr_ena;
  logic       w_if_id_wr_ena;
  logic       w_id_ex_wr_ena;
  logic       w_ex_mem_wr_ena;
  logic       w_if_id_flush;
  logic       w_id_ex_flush;

  // Load-use: EX load to a real register that the ID instruction reads.
  assign w_lu = hz.ex_mem_rd & hz.ex_reg_wr_ena & (hz.ex_rd_addr != ZERO_REG) &
                ((hz.id_rs_used & (hz.id_rs_addr == hz.ex_rd_addr)) |
                 (hz.id_rt_used & (hz.id_rt_addr == hz.ex_rd_addr)));

  stall_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_stall_watchdog (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_ena       (r_state != FAULT),
    .i_mem_stall (hz.mem_stall),
    .o_trip_c    (w_trip)
  );

  // State register; fault mirrors residence in FAULT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_fault <= (w_state_nxt == FAULT);
    end
  end

  // Next state and Mealy stage controls.
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_wr_ena     = 1'b1;
    w_if_id_wr_ena  = 1'b1;
    w_id_ex_wr_ena  = 1'b1;
    w_ex_mem_wr_ena = 1'b1;
    w_if_id_flush   = 1'b0;
    w_id_ex_flush   = 1'b0;
    w_lu_take       = 1'b0;
    w_br_take       = 1'b0;
    w_freeze        = 1'b0;

    unique case (r_state)
      // MEM_WAIT releasing behaves exactly like RUN in the same cycle.
      RUN, MEM_WAIT: begin
        if (hz.mem_stall) begin
          w_pc_wr_ena     = 1'b0;
          w_if_id_wr_ena  = 1'b0;
          w_id_ex_wr_ena  = 1'b0;
          w_ex_mem_wr_ena = 1'b0;
          w_freeze        = 1'b1;
          w_state_nxt     = w_trip ? FAULT : MEM_WAIT;
        end else begin
          w_state_nxt = RUN;
          if (hz.ex_branch_taken) begin
            // ID holds a wrong-path instruction, so any load-use is moot.
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
            w_br_take     = 1'b1;
          end else if (w_lu) begin
            w_pc_wr_ena    = 1'b0;
            w_if_id_wr_ena = 1'b0;
            w_id_ex_flush  = 1'b1;
            w_lu_take      = 1'b1;
          end
        end
      end
      FAULT: begin
        w_pc_wr_ena     = 1'b0;
        w_if_id_wr_ena  = 1'b0;
        w_id_ex_wr_ena  = 1'b0;
        w_ex_mem_wr_ena = 1'b0;
        if (hz.fault_clr) begin
          w_state_nxt = RUN;
        end
      end
      default: begin
        w_pc_wr_ena     = 1'b0;
        w_if_id_wr_ena  = 1'b0;
        w_id_ex_wr_ena  = 1'b0;
        w_ex_mem_wr_ena = 1'b0;
        w_state_nxt     = RUN;
      end
    endcase
  end

  assign hz.pc_wr_ena     = w_pc_wr_ena;
  assign hz.if_id_wr_ena  = w_if_id_wr_ena;
  assign hz.id_ex_wr_ena  = w_id_ex_wr_ena;
  assign hz.ex_mem_wr_ena = w_ex_mem_wr_ena;
  assign hz.if_id_flush   = w_if_id_flush;
  assign hz.id_ex_flush   = w_id_ex_flush;
  assign hz.fault         = r_fault;

`ifdef HAZARD_STATS_EN
  logic [CNT_WIDTH-1:0] r_stall_cycles;
  logic [CNT_WIDTH-1:0] r_mem_wait_cycles;
  logic [CNT_WIDTH-1:0] r_flush_count;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cycles    <= '0;
      r_mem_wait_cycles <= '0;
      r_flush_count     <= '0;
    end else begin
      if (w_lu_take && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + CNT_WIDTH'(1);
      end
      if (w_freeze && (r_mem_wait_cycles != '1)) begin
        r_mem_wait_cycles <= r_mem_wait_cycles + CNT_WIDTH'(1);
      end
      if (w_br_take && (r_flush_count != '1)) begin
        r_flush_count <= r_flush_count + CNT_WIDTH'(1);
      end
    end
  end

  assign hz.stall_cycles    = r_stall_cycles;
  assign hz.mem_wait_cycles = r_mem_wait_cycles;
  assign hz.flush_count     = r_flush_count;
`else
  logic w_unused_stats;
  assign w_unused_stats     = w_lu_take ^ w_br_take ^ w_freeze;
  assign hz.stall_cycles    = CNT_WIDTH'(0);
  assign hz.mem_wait_cycles = CNT_WIDTH'(0);
  assign hz.flush_count     = CNT_WIDTH'(0);
`endif

endmodule : hazard_control_unit

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit with TIMEOUT=4.
// Control vector order: {pc, if_id, id_ex, ex_mem enables, if_id_flush, id_ex_flush}.
module tb_hazard_control_unit;
  import udlx_pkg::*;

  localparam int unsigned RAW = 5;
  localparam int unsigned CW  = 32;

  localparam logic [5:0] CTL_IDLE   = 6'b111100;
  localparam logic [5:0] CTL_LU     = 6'b001101;
  localparam logic [5:0] CTL_BRANCH = 6'b111111;
  localparam logic [5:0] CTL_FROZEN = 6'b000000;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  hazard_control_unit_if #(.REG_ADDR_WIDTH(RAW), .CNT_WIDTH(CW)) bus ();

  hazard_control_unit #(
    .REG_ADDR_WIDTH (RAW),
    .TIMEOUT        (4),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] ctl_vec();
    return {bus.pc_wr_ena, bus.if_id_wr_ena, bus.id_ex_wr_ena,
            bus.ex_mem_wr_ena, bus.if_id_flush, bus.id_ex_flush};
  endfunction

  // Expected counter value depends on whether statistics are built.
  function automatic logic [31:0] exp_cnt(input int v);
`ifdef HAZARD_STATS_EN
    return 32'(v);
`else
    return 32'(v - v);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.id_rs_addr      = '0;
    bus.id_rt_addr      = '0;
    bus.id_rs_used      = 1'b0;
    bus.id_rt_used      = 1'b0;
    bus.ex_rd_addr      = '0;
    bus.ex_reg_wr_ena   = 1'b0;
    bus.ex_mem_rd       = 1'b0;
    bus.ex_branch_taken = 1'b0;
    bus.mem_stall       = 1'b0;
    bus.fault_clr       = 1'b0;
  endtask

  task automatic load_to(input logic [4:0] rd);
    bus.ex_mem_rd     = 1'b1;
    bus.ex_reg_wr_ena = 1'b1;
    bus.ex_rd_addr    = rd;
  endtask

  task automatic check_cnts(input string tag, input int st, input int mw, input int fl);
    check({tag, ".stall"},    bus.stall_cycles,    exp_cnt(st));
    check({tag, ".memwait"},  bus.mem_wait_cycles, exp_cnt(mw));
    check({tag, ".flush"},    bus.flush_count,     exp_cnt(fl));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("reset.ctl", 32'(ctl_vec()), 32'(CTL_IDLE));
    check("reset.fault", 32'(bus.fault), 32'd0);
    check_cnts("reset", 0, 0, 0);

    // Load r5, ID reads rs=r5.
    load_to(5'd5);
    bus.id_rs_addr = 5'd5; bus.id_rs_used = 1'b1;
    #1 check("lu_rs.ctl", 32'(ctl_vec()), 32'(CTL_LU));
    step();
    idle_inputs();
    #1 check("lu_rs.after", 32'(ctl_vec()), 32'(CTL_IDLE));
    check("lu_rs.stall", bus.stall_cycles, exp_cnt(1));

    // Match via rt.
    load_to(5'd9);
    bus.id_rt_addr = 5'd9; bus.id_rt_used = 1'b1;
    #1 check("lu_rt.ctl", 32'(ctl_vec()), 32'(CTL_LU));
    step();
    idle_inputs();

    // Address matches but operand not used.
    load_to(5'd9);
    bus.id_rs_addr = 5'd9; bus.id_rt_addr = 5'd9;
    #1 check("unused_src.ctl", 32'(ctl_vec()), 32'(CTL_IDLE));
    step();

    // Load to r0 never stalls.
    load_to(5'd0);
    bus.id_rs_addr = 5'd0; bus.id_rs_used = 1'b1;
    #1 check("r0.ctl", 32'(ctl_vec()), 32'(CTL_IDLE));
    step();

    // Load without register write, then ALU producer: forwarding covers both.
    load_to(5'd6);
    bus.ex_reg_wr_ena = 1'b0;
    bus.id_rs_addr = 5'd6; bus.id_rs_used = 1'b1;
    #1 check("no_wr.ctl", 32'(ctl_vec()), 32'(CTL_IDLE));
    bus.ex_reg_wr_ena = 1'b1; bus.ex_mem_rd = 1'b0;
    #1 check("alu.ctl", 32'(ctl_vec()), 32'(CTL_IDLE));
    step();
    check_cnts("pre_br", 2, 0, 0);
    idle_inputs();

    // Taken branch overrides a same-cycle load-use on r3.
    load_to(5'd3);
    bus.id_rs_addr = 5'd3; bus.id_rs_used = 1'b1;
    bus.ex_branch_taken = 1'b1;
    #1 check("br_lu.ctl", 32'(ctl_vec()), 32'(CTL_BRANCH));
    step();
    idle_inputs();
    #1 check_cnts("br_lu", 2, 0, 1);

    // Memory stall for 3 cycles during a load-use on r7, then one bubble.
    load_to(5'd7);
    bus.id_rt_addr = 5'd7; bus.id_rt_used = 1'b1;
    bus.mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("memstall%0d.ctl", i), 32'(ctl_vec()), 32'(CTL_FROZEN));
      step();
    end
    bus.mem_stall = 1'b0;
    #1 check("mem_release.ctl", 32'(ctl_vec()), 32'(CTL_LU));
    step();
    idle_inputs();
    #1 check("mem_release.fault", 32'(bus.fault), 32'd0);
    check_cnts("mem_release", 3, 3, 1);

    // Watchdog: fault after the 4th consecutive stall edge.
    bus.mem_stall = 1'b1;
    step(); step(); step();
    check("wd3.fault", 32'(bus.fault), 32'd0);
    check("wd3.ctl", 32'(ctl_vec()), 32'(CTL_FROZEN));
    step();
    check("wd4.fault", 32'(bus.fault), 32'd1);
    check("wd4.memwait", bus.mem_wait_cycles, exp_cnt(7));
    bus.mem_stall = 1'b0;
    #1 check("fault_hold.ctl", 32'(ctl_vec()), 32'(CTL_FROZEN));
    step();
    check("fault_hold.fault", 32'(bus.fault), 32'd1);
    bus.mem_stall = 1'b1;
    step();
    check("fault_stall.memwait", bus.mem_wait_cycles, exp_cnt(7));
    bus.mem_stall = 1'b0;
    bus.fault_clr = 1'b1;
    #1 check("fault_clr.ctl", 32'(ctl_vec()), 32'(CTL_FROZEN));
    step();
    bus.fault_clr = 1'b0;
    #1 check("fault_clr.fault", 32'(bus.fault), 32'd0);
    check("fault_clr.after", 32'(ctl_vec()), 32'(CTL_IDLE));

    // Re-trip, then reset while in FAULT with mem_stall still high.
    bus.mem_stall = 1'b1;
    step(); step(); step(); step();
    check("retrip.fault", 32'(bus.fault), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1 check("rst_fault.fault", 32'(bus.fault), 32'd0);
    check_cnts("rst_fault", 0, 0, 0);
    check("rst_fault.ctl", 32'(ctl_vec()), 32'(CTL_FROZEN));
    step(); step(); step();
    check("post_rst3.fault", 32'(bus.fault), 32'd0);
    step();
    check("post_rst4.fault", 32'(bus.fault), 32'd1);
    check("post_rst4.memwait", bus.mem_wait_cycles, exp_cnt(4));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_hazard_control_unit
